mac_seq_ctrl: RTL and testbench

Sequencer for the single-precision MAC datapath. Accepts a job descriptor (vector length), clears the MAC accumulator, and streams data/weight operand pairs into the MAC under a valid/ready handshake. It then waits out the MAC pipeline latency, captures the accumulated IEEE-754 result and returns it on a result handshake. Sits between the attention/FFN tile scheduler and one MAC lane.

---
 rtl/mac_seq_ctrl_if.sv | 45 ++++
 rtl/mac_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_mac_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mac_seq_ctrl_if : job, operand, MAC-lane and result signals of the MAC
//                   sequencer.                                 Revision 1.0
// ---------------------------------------------------------------------------
interface mac_seq_ctrl_if #(
  parameter int DW    = 32,
  parameter int LEN_W = 10
) ();
  logic             cfg_valid;
  logic             cfg_ready;
  logic [LEN_W-1:0] cfg_len;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic [DW-1:0]    in_weight;
  logic             mac_rst_n;
  logic [DW-1:0]    mac_data_value;
  logic             mac_data_valid;
  logic [DW-1:0]    mac_weight_value;
  logic             mac_weight_valid;
  logic [DW-1:0]    mac_out;
  logic             res_valid;
  logic             res_ready;
  logic [DW-1:0]    res_data;
  logic             busy;

  // Scheduler / MAC-lane side of the sequencer
  modport master (
    output cfg_valid, cfg_len, abort, in_valid, in_data, in_weight,
           mac_out, res_ready,
    input  cfg_ready, in_ready, mac_rst_n, mac_data_value, mac_data_valid,
           mac_weight_value, mac_weight_valid, res_valid, res_data, busy
  );

  // The sequencer itself
  modport slave (
    input  cfg_valid, cfg_len, abort, in_valid, in_data, in_weight,
           mac_out, res_ready,
    output cfg_ready, in_ready, mac_rst_n, mac_data_value, mac_data_valid,
           mac_weight_value, mac_weight_valid, res_valid, res_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mac_seq_ctrl : clears one MAC lane, streams a job's operand pairs into it,
//                waits out the MAC latency and returns the dot product.
//                                                              Revision 1.0
// ---------------------------------------------------------------------------
module mac_seq_ctrl #(
  parameter int DW      = 32,
  parameter int LEN_W   = 10,
  parameter int MAC_LAT = 2
) (
  input  wire           clk,
  input  wire           rst,
  mac_seq_ctrl_if.slave bus
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_CLEAR  = 3'd1;
  localparam logic [2:0] c_STREAM = 3'd2;
  localparam logic [2:0] c_DRAIN  = 3'd3;
  localparam logic [2:0] c_DONE   = 3'd4;

  localparam int c_DRN_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  logic [2:0]         r_state;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_cnt;
  logic [c_DRN_W-1:0] r_drain;
  logic               r_mac_rst_n;
  logic               r_mac_valid;
  logic [DW-1:0]      r_mac_data;
  logic [DW-1:0]      r_mac_weight;
  logic [DW-1:0]      r_res_data;

  logic w_abort;
  logic w_last;

  assign w_abort = bus.abort && (r_state != c_IDLE);
  assign w_last  = (r_cnt == (r_len - LEN_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_len        <= '0;
      r_cnt        <= '0;
      r_drain      <= '0;
      r_mac_rst_n  <= 1'b0;
      r_mac_valid  <= 1'b0;
      r_mac_data   <= '0;
      r_mac_weight <= '0;
      r_res_data   <= '0;
    end else begin
      // Operands are single-cycle pulses; the accumulator clear is too
      r_mac_rst_n <= 1'b1;
      r_mac_valid <= 1'b0;
      if (w_abort) begin
        r_state     <= c_IDLE;
        r_mac_rst_n <= 1'b0;
      end else begin
        case (r_state)
          c_IDLE: begin
            if (bus.cfg_valid) begin
              r_len <= bus.cfg_len;
              r_cnt <= '0;
              if (bus.cfg_len == '0) begin
                r_res_data <= '0;
                r_state    <= c_DONE;
              end else begin
                r_mac_rst_n <= 1'b0;
                r_state     <= c_CLEAR;
              end
            end
          end
          c_CLEAR: begin
            r_cnt   <= '0;
            r_state <= c_STREAM;
          end
          c_STREAM: begin
            if (bus.in_valid) begin
              r_mac_data   <= bus.in_data;
              r_mac_weight <= bus.in_weight;
              r_mac_valid  <= 1'b1;
              r_cnt        <= r_cnt + LEN_W'(1);
              if (w_last) begin
                r_drain <= c_DRN_W'(MAC_LAT);
                r_state <= c_DRAIN;
              end
            end
          end
          c_DRAIN: begin
            // Zero count marks the cycle the last product reaches mac_out
            if (r_drain == '0) begin
              r_res_data <= bus.mac_out;
              r_state    <= c_DONE;
            end else begin
              r_drain <= r_drain - c_DRN_W'(1);
            end
          end
          c_DONE: begin
            if (bus.res_ready) begin
              r_state <= c_IDLE;
            end
          end
          default: r_state <= c_IDLE;
        endcase
      end
    end
  end

  assign bus.cfg_ready        = (r_state == c_IDLE);
  assign bus.in_ready         = (r_state == c_STREAM);
  assign bus.busy             = (r_state != c_IDLE);
  assign bus.res_valid        = (r_state == c_DONE);
  assign bus.res_data         = r_res_data;
  assign bus.mac_rst_n        = r_mac_rst_n;
  assign bus.mac_data_value   = r_mac_data;
  assign bus.mac_data_valid   = r_mac_valid;
  assign bus.mac_weight_value = r_mac_weight;
  assign bus.mac_weight_valid = r_mac_valid;

endmodule
`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mac_seq_ctrl : directed and random jobs against a job-timeline model of
//                   the sequencer and a behavioural MAC lane.  Revision 1.0
// ---------------------------------------------------------------------------
module tb_mac_seq_ctrl;
  localparam int DW      = 32;
  localparam int LEN_W   = 10;
  localparam int MAC_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.DW(DW), .LEN_W(LEN_W)) bus ();

  mac_seq_ctrl #(.DW(DW), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    e = int'(b[30:23]) - 127;
    m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** real'(e));
    return b[31] ? -m : m;
  endfunction

  // Exact for the small integer values used here
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] rand_op();
    return r2f(real'($urandom_range(0, 15)));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural MAC lane: product stage then accumulator, MAC_LAT = 2
  real  m_prod = 0.0;
  real  m_acc  = 0.0;
  logic m_pv   = 1'b0;
  always @(posedge clk) begin
    if (bus.mac_rst_n === 1'b0) begin
      m_pv  <= 1'b0;
      m_acc <= 0.0;
    end else begin
      m_pv   <= (bus.mac_data_valid === 1'b1) && (bus.mac_weight_valid === 1'b1);
      m_prod <= f2r(bus.mac_data_value) * f2r(bus.mac_weight_value);
      if (m_pv) m_acc <= m_acc + m_prod;
    end
  end
  assign bus.mac_out = r2f(m_acc);

  // Job-timeline reference: variables describe the cycle after each update
  bit          m_ok = 1'b0;
  bit          m_active, m_ir, m_irw, m_rv, e_mrst, e_mv;
  int          m_pend, m_len, m_cnt, mv_cnt;
  real         m_sum;
  logic [31:0] e_d, e_w, e_res;

  always @(negedge clk) begin
    if (m_ok) begin
      chk("cfg_ready", 32'(bus.cfg_ready), 32'(!m_active));
      chk("busy", 32'(bus.busy), 32'(m_active));
      chk("in_ready", 32'(bus.in_ready), 32'(m_ir));
      chk("res_valid", 32'(bus.res_valid), 32'(m_rv));
      chk("res_data", bus.res_data, e_res);
      chk("mac_rst_n", 32'(bus.mac_rst_n), 32'(e_mrst));
      chk("mac_data_valid", 32'(bus.mac_data_valid), 32'(e_mv));
      chk("mac_weight_valid", 32'(bus.mac_weight_valid), 32'(e_mv));
      chk("mac_data_value", bus.mac_data_value, e_d);
      chk("mac_weight_value", bus.mac_weight_value, e_w);
      if (bus.mac_data_valid === 1'b1) mv_cnt++;
    end
    if (rst) begin
      m_active = 0; m_ir = 0; m_irw = 0; m_rv = 0; m_pend = 0;
      e_mrst = 0; e_mv = 0; e_d = '0; e_w = '0; e_res = '0;
      m_ok = 1;
    end else if (m_ok) begin
      e_mrst = 1;
      e_mv   = 0;
      if (m_active && bus.abort) begin
        m_active = 0; m_ir = 0; m_irw = 0; m_rv = 0; m_pend = 0; e_mrst = 0;
      end else if (!m_active) begin
        if (bus.cfg_valid) begin
          m_active = 1; m_len = int'(bus.cfg_len); m_cnt = 0; m_sum = 0.0; mv_cnt = 0;
          if (m_len == 0) begin
            m_rv = 1; e_res = '0;
          end else begin
            m_irw = 1; e_mrst = 0;
          end
        end
      end else if (m_irw) begin
        m_irw = 0; m_ir = 1;
      end else if (m_ir) begin
        if (bus.in_valid) begin
          e_mv = 1; e_d = bus.in_data; e_w = bus.in_weight;
          m_sum += f2r(bus.in_data) * f2r(bus.in_weight);
          m_cnt++;
          if (m_cnt == m_len) begin
            m_ir = 0; m_pend = MAC_LAT + 1;
          end
        end
      end else if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) begin
          m_rv = 1; e_res = r2f(m_sum);
        end
      end else if (m_rv && bus.res_ready) begin
        m_rv = 0; m_active = 0;
      end
    end
  end

  // Stimulus
  bit               c_rst = 1'b1, c_cfg_valid = 1'b0, c_abort = 1'b0, c_res_ready = 1'b0;
  logic [LEN_W-1:0] c_cfg_len = '0;
  int               vprob = 100;
  int               job_hs = 0;
  bit               vpat[$];
  logic [31:0]      opa[$], opb[$];

  task automatic step();
    @(posedge clk);
    #1;
    rst           = c_rst;
    bus.cfg_valid = c_cfg_valid;
    bus.cfg_len   = c_cfg_len;
    bus.abort     = c_abort;
    bus.res_ready = c_res_ready;
    if (bus.in_ready) begin
      if (vpat.size() > 0) bus.in_valid = vpat.pop_front();
      else                 bus.in_valid = (int'($urandom_range(0, 99)) < vprob);
    end else begin
      bus.in_valid = 1'b0;
    end
    bus.in_data   = (opa.size() > 0) ? opa[0] : rand_op();
    bus.in_weight = (opb.size() > 0) ? opb[0] : rand_op();
    @(negedge clk);
    if (bus.in_valid && bus.in_ready && !bus.abort && !rst) begin
      job_hs++;
      if (opa.size() > 0) void'(opa.pop_front());
      if (opb.size() > 0) void'(opb.pop_front());
    end
  endtask

  // kill: 0 none, 1 abort, 2 rst -- applied after kill_at accepted pairs
  task automatic run_job(input int len, input int vp, input int hold, input bit lit_en,
                         input logic [31:0] lit, input int kill, input int kill_at,
                         input int exp_mv);
    int guard;
    vprob = vp;
    guard = 0;
    while (!bus.cfg_ready && guard < 50) begin step(); guard++; end
    c_cfg_valid = 1'b1;
    c_cfg_len   = LEN_W'(len);
    c_res_ready = (hold == 0);
    job_hs      = 0;
    step();
    c_cfg_valid = 1'b0;
    guard = 0;
    while (guard < 3000) begin
      if (kill != 0 && job_hs >= kill_at) begin
        if (kill == 1) c_abort = 1'b1; else c_rst = 1'b1;
        step();
        c_abort = 1'b0; c_rst = 1'b0; c_res_ready = 1'b0;
        opa.delete(); opb.delete(); vpat.delete();
        return;
      end
      if (bus.res_valid) break;
      step();
      guard++;
    end
    if (bus.res_valid !== 1'b1) begin
      n_assert++; n_fail++;
      $display("FAIL result_timeout: got no res_valid, expected one within 3000 cycles");
      c_res_ready = 1'b0;
      return;
    end
    if (lit_en) chk("res_literal", bus.res_data, lit);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        c_cfg_valid = (i == 1);
        c_cfg_len   = LEN_W'(3);
        step();
      end
      c_cfg_valid = 1'b0;
      c_res_ready = 1'b1;
      step();
    end
    c_res_ready = 1'b0;
    if (exp_mv >= 0) chk("mac_valid_cycles", 32'(mv_cnt), 32'(exp_mv));
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
    opa.push_back(a);
    opb.push_back(b);
  endtask

  initial begin
    int len, kill;
    bus.cfg_valid = 0; bus.cfg_len = '0; bus.abort = 0; bus.in_valid = 0;
    bus.in_data = '0; bus.in_weight = '0; bus.res_ready = 0;
    repeat (3) step();
    c_rst = 1'b0;
    step();

    // 5.0 x 5.0 four times = 100.0
    repeat (4) push_pair(32'h40A00000, 32'h40A00000);
    run_job(4, 100, 0, 1'b1, 32'h42C80000, 0, 0, 4);

    repeat (4) push_pair(32'h40A00000, 32'h40A00000);
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    run_job(4, 100, 0, 1'b1, 32'h42C80000, 0, 0, 4);

    run_job(0, 100, 0, 1'b1, 32'h00000000, 0, 0, 0);

    // 1*2 + 3*4 = 14.0, result held for 10 cycles
    push_pair(32'h3F800000, 32'h40000000);
    push_pair(32'h40400000, 32'h40800000);
    run_job(2, 100, 10, 1'b1, 32'h41600000, 0, 0, 2);

    repeat (4) push_pair(32'h40E00000, 32'h40E00000);
    run_job(4, 100, 0, 1'b0, 32'h0, 2, 2, -1);
    push_pair(32'h3F800000, 32'h40000000);
    push_pair(32'h40400000, 32'h40800000);
    run_job(2, 100, 0, 1'b1, 32'h41600000, 0, 0, 2);

    run_job(3, 100, 0, 1'b0, 32'h0, 1, 3, -1);
    repeat (2) step();

    for (int j = 0; j < 40; j++) begin
      len  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
      kill = ($urandom_range(0, 7) == 0) ? 1 : (($urandom_range(0, 15) == 0) ? 2 : 0);
      run_job(len, int'($urandom_range(30, 100)), int'($urandom_range(0, 4)), 1'b0, 32'h0,
              kill, int'($urandom_range(0, len)), (kill == 0) ? len : -1);
      if ($urandom_range(0, 1) == 1) step();
    end

    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
